pipe_mem_bus_master: RTL and testbench

// Single Avalon-MM master shared by the pipelined CPU's fetch stage and MEM stage. Carries the

---
 rtl/pipe_mem_bus_master.sv | 192 +++++++++++++++++++
 tb/tb_pipe_mem_bus_master.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_bus_master.sv
// pipe_mem_bus_master: one Avalon-MM master shared by the fetch stage and the
// MEM stage. The request source is chosen by fetch_mem_sel in IDLE, and all
// Avalon outputs are held until waitrequest drops or the wait counter times out.
// Optional feature: define PIPE_MEMBUS_FETCH_BUF_EN for a one-entry fetch buffer.
module pipe_mem_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetch_mem_sel,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        ls_read,
  input  logic        ls_write,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_byteen,
  output logic [31:0] ls_rdata,
  output logic        ls_done,
  output logic        mem_busy,
  output logic        bus_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, cnt_d;
  logic [31:0]      address_d, writedata_d, if_rdata_d, ls_rdata_d;
  logic             read_d, write_d, if_done_d, ls_done_d, bus_error_d;
  logic [3:0]       byteen_d;

  logic        fetch_req, ls_req, fetch_misaligned, fetch_hit, abort;
  logic [31:0] hit_data;
  logic        unused_ls_addr_lo;

  assign fetch_req        = fetch_mem_sel & if_req;
  assign ls_req           = ~fetch_mem_sel & (ls_read | ls_write);
  assign fetch_misaligned = fetch_req & (if_addr[1:0] != 2'b00);
  assign abort            = waitrequest & (wait_cnt == CNT_LAST);
  // Load/store byte position travels on ls_byteen; the word address carries no low bits.
  assign unused_ls_addr_lo = ^ls_addr[1:0];

  // Busy while a bus transfer is in flight or about to be issued from IDLE.
  assign mem_busy = (state != IDLE) | (fetch_req & ~fetch_misaligned & ~fetch_hit) | ls_req;

`ifdef PIPE_MEMBUS_FETCH_BUF_EN
  logic        buf_valid;
  logic [31:0] buf_tag, buf_instr;

  assign fetch_hit = fetch_req & ~fetch_misaligned & buf_valid & (buf_tag == if_addr);
  assign hit_data  = buf_instr;

  // Remember the last good fetch; any store leaving DATA on the tagged word drops it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_instr <= '0;
    end else if (state == FETCH && !waitrequest) begin
      buf_valid <= 1'b1;
      buf_tag   <= address;
      buf_instr <= readdata;
    end else if (state == DATA && write && (!waitrequest || abort) &&
                 address[31:2] == buf_tag[31:2]) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign fetch_hit = 1'b0;
  assign hit_data  = '0;
`endif

  // Register every FSM-computed output and the wait counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      bus_error  <= 1'b0;
    end else begin
      state      <= state_d;
      wait_cnt   <= cnt_d;
      address    <= address_d;
      read       <= read_d;
      write      <= write_d;
      writedata  <= writedata_d;
      byteenable <= byteen_d;
      if_rdata   <= if_rdata_d;
      ls_rdata   <= ls_rdata_d;
      if_done    <= if_done_d;
      ls_done    <= ls_done_d;
      bus_error  <= bus_error_d;
    end
  end

  // Next state and next output values; requests are only looked at in IDLE.
  always_comb begin
    state_d     = state;
    cnt_d       = wait_cnt;
    address_d   = address;
    read_d      = read;
    write_d     = write;
    writedata_d = writedata;
    byteen_d    = byteenable;
    if_rdata_d  = if_rdata;
    ls_rdata_d  = ls_rdata;
    if_done_d   = 1'b0;
    ls_done_d   = 1'b0;
    bus_error_d = bus_error;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (fetch_req) begin
          if (fetch_misaligned) begin
            bus_error_d = 1'b1;
            if_done_d   = 1'b1;
            if_rdata_d  = '0;
          end else if (fetch_hit) begin
            if_done_d  = 1'b1;
            if_rdata_d = hit_data;
          end else begin
            state_d   = FETCH;
            address_d = {if_addr[31:2], 2'b00};
            read_d    = 1'b1;
            write_d   = 1'b0;
            byteen_d  = 4'hF;
          end
        end else if (ls_req) begin
          state_d     = DATA;
          address_d   = {ls_addr[31:2], 2'b00};
          read_d      = ls_read;
          write_d     = ~ls_read;
          writedata_d = ls_wdata;
          byteen_d    = ls_byteen;
        end
      end
      FETCH, DATA: begin
        if (!waitrequest) begin
          state_d = IDLE;
          cnt_d   = '0;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (state == FETCH) begin
            if_rdata_d = readdata;
            if_done_d  = 1'b1;
          end else begin
            ls_done_d = 1'b1;
            if (read) ls_rdata_d = readdata;
          end
        end else if (abort) begin
          state_d     = IDLE;
          cnt_d       = '0;
          read_d      = 1'b0;
          write_d     = 1'b0;
          bus_error_d = 1'b1;
          if (state == FETCH) begin
            if_rdata_d = '0;
            if_done_d  = 1'b1;
          end else begin
            ls_rdata_d = '0;
            ls_done_d  = 1'b1;
          end
        end else if (wait_cnt != CNT_MAX) begin
          cnt_d = wait_cnt + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_mem_bus_master.sv
// tb_pipe_mem_bus_master: directed stimulus with a queue-based scoreboard.
// Define PIPE_MEMBUS_FETCH_BUF_EN for both bench and design to cover the fetch buffer.
module tb_pipe_mem_bus_master;

  typedef struct {
    logic        valid;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          len;
  } bus_t;

  typedef struct {
    logic        fetch;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
  } done_t;

  logic        clk, reset_n, fetch_mem_sel, if_req, if_done, ls_read, ls_write, ls_done;
  logic        mem_busy, bus_error, read, write, waitrequest;
  logic [31:0] if_addr, if_rdata, ls_addr, ls_wdata, ls_rdata, address, writedata, readdata;
  logic [3:0]  ls_byteen, byteenable;

  bus_t        bus_q[$];
  done_t       done_q[$];
  logic        in_bus;
  int unsigned cfg_wait;
  logic [31:0] cfg_rdata;
  int          n_checks, n_fail;

  pipe_mem_bus_master #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .fetch_mem_sel(fetch_mem_sel),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .ls_read(ls_read), .ls_write(ls_write), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_byteen(ls_byteen), .ls_rdata(ls_rdata), .ls_done(ls_done),
    .mem_busy(mem_busy), .bus_error(bus_error), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be, input int len);
    bus_t b;
    b.valid = 1'b1; b.rd = rd; b.wr = wr; b.addr = a; b.wdata = wd; b.be = be; b.len = len;
    bus_q.push_back(b);
  endtask

  task automatic push_done(input logic f, input logic [31:0] d, input logic cd, input logic err);
    done_t e;
    e.fetch = f; e.data = d; e.chk_data = cd; e.err = err;
    done_q.push_back(e);
  endtask

  task automatic release_req();
    if_req = 1'b0; ls_read = 1'b0; ls_write = 1'b0;
  endtask

  task automatic req_fetch(input logic [31:0] a);
    fetch_mem_sel = 1'b1; if_req = 1'b1; if_addr = a;
  endtask

  task automatic req_ls(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    fetch_mem_sel = 1'b0; ls_read = rd; ls_write = wr; ls_addr = a; ls_wdata = wd; ls_byteen = be;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(done_q.size() == 0 && bus_q.size() == 0 && !in_bus) && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    if (!(done_q.size() == 0 && bus_q.size() == 0 && !in_bus)) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: actual pending=%0d required pending=0", name,
               done_q.size() + bus_q.size());
    end else begin
      check({name, "_idle_busy"}, 32'(mem_busy), 32'd0);
    end
  endtask

  // Request is already driven; hold it across one edge, then wait for the scoreboard.
  task automatic finish_txn(input string name, input logic chk_busy, input logic exp_busy);
    #1;
    if (chk_busy) check({name, "_req_busy"}, 32'(mem_busy), 32'(exp_busy));
    @(negedge clk); #1;
    release_req();
    drain(name);
  endtask

  task automatic do_reset();
    release_req();
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
  endtask

  // Slave model: stalls each transfer for cfg_wait cycles, then accepts it.
  initial begin : slave
    int unsigned stall;
    logic        active;
    stall = 0; active = 1'b0;
    waitrequest = 1'b0; readdata = '0;
    forever begin
      @(negedge clk);
      readdata = cfg_rdata;
      if (read | write) begin
        if (!active) begin active = 1'b1; stall = 0; end
        waitrequest = (stall < cfg_wait);
        stall++;
      end else begin
        active = 1'b0;
        waitrequest = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT shows a strobe or a done pulse.
  initial begin : monitor
    bus_t  cur;
    done_t de;
    int    len;
    in_bus = 1'b0; len = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_bus = 1'b0;
        continue;
      end
      if (read | write) begin
        if (!in_bus) begin
          in_bus = 1'b1; len = 0;
          if (bus_q.size() == 0) begin
            cur = '{default: 0};
            n_checks++; n_fail++;
            $display("FAIL stray_strobe: actual addr %h required no transfer", address);
          end else begin
            cur = bus_q.pop_front();
          end
        end
        if (cur.valid) begin
          check("bus_rd_wr", 32'({read, write}), 32'({cur.rd, cur.wr}));
          check("bus_address", address, cur.addr);
          check("bus_byteenable", 32'(byteenable), 32'(cur.be));
          if (cur.wr) check("bus_writedata", writedata, cur.wdata);
        end
        len++;
      end else if (in_bus) begin
        if (cur.valid && cur.len > 0) check("bus_len", 32'(len), 32'(cur.len));
        in_bus = 1'b0;
      end
      if (if_done | ls_done) begin
        if (done_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL stray_done: actual if_done=%b ls_done=%b required none", if_done, ls_done);
        end else begin
          de = done_q.pop_front();
          check("done_which", 32'({if_done, ls_done}), 32'({de.fetch, ~de.fetch}));
          if (de.chk_data) check("done_data", de.fetch ? if_rdata : ls_rdata, de.data);
          check("done_bus_error", 32'(bus_error), 32'(de.err));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual time limit hit required finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    n_checks = 0; n_fail = 0;
    cfg_wait = 0; cfg_rdata = '0;
    fetch_mem_sel = 1'b0; if_req = 1'b0; if_addr = '0;
    ls_read = 1'b0; ls_write = 1'b0; ls_addr = '0; ls_wdata = '0; ls_byteen = '0;
    reset_n = 1'b0;
    do_reset();
    check("rst_read", 32'(read), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_address", address, 32'd0);
    check("rst_writedata", writedata, 32'd0);
    check("rst_byteenable", 32'(byteenable), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);
    check("rst_dones", 32'({if_done, ls_done}), 32'd0);
    check("rst_mem_busy", 32'(mem_busy), 32'd0);
    check("rst_bus_error", 32'(bus_error), 32'd0);
    reset_n = 1'b1;

    // Boot fetch, zero wait
    cfg_wait = 0; cfg_rdata = 32'h1234_5678;
    push_bus(1, 0, 32'hBFC0_0000, '0, 4'hF, 1); push_done(1, 32'h1234_5678, 1, 0);
    req_fetch(32'hBFC0_0000); finish_txn("fetch_boot", 1, 1);

    // Load with 3 wait cycles: strobe held 4 cycles
    cfg_wait = 3; cfg_rdata = 32'hCAFE_F00D;
    push_bus(1, 0, 32'h0000_1000, '0, 4'hF, 4); push_done(0, 32'hCAFE_F00D, 1, 0);
    req_ls(1, 0, 32'h0000_1000, 32'h0, 4'hF); finish_txn("load_wait3", 1, 1);

    // Byte load: low address bits dropped, lane on byteenable
    cfg_wait = 1; cfg_rdata = 32'h1122_3344;
    push_bus(1, 0, 32'h0000_1000, '0, 4'h8, 2); push_done(0, 32'h1122_3344, 1, 0);
    req_ls(1, 0, 32'h0000_1003, 32'h0, 4'h8); finish_txn("load_byte", 1, 1);

    // Halfword store, 2 wait cycles
    cfg_wait = 2;
    push_bus(0, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 3); push_done(0, '0, 0, 0);
    req_ls(0, 1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011); finish_txn("store_half", 1, 1);

    // Read and write together: read wins; input noise mid-transfer is ignored
    cfg_wait = 5; cfg_rdata = 32'h0BAD_F00D;
    push_bus(1, 0, 32'h0000_3008, '0, 4'hF, 6); push_done(0, 32'h0BAD_F00D, 1, 0);
    req_ls(1, 1, 32'h0000_3008, 32'h5555_5555, 4'hF);
    #1; check("rdwr_req_busy", 32'(mem_busy), 32'd1);
    @(negedge clk); #1;
    release_req();
    req_fetch(32'h0000_0600); ls_write = 1'b1; ls_addr = 32'h0000_0ABC;
    @(negedge clk); @(negedge clk); #1;
    release_req();
    check("mid_xfer_busy", 32'(mem_busy), 32'd1);
    drain("read_wins");

    // Fetch buffer behaviour (or plain re-fetch without it)
    cfg_wait = 0; cfg_rdata = 32'hAAAA_0001;
    push_bus(1, 0, 32'h0000_0400, '0, 4'hF, 1); push_done(1, 32'hAAAA_0001, 1, 0);
    req_fetch(32'h0000_0400); finish_txn("buf_fill", 1, 1);
    cfg_rdata = 32'hFFFF_0000;
`ifdef PIPE_MEMBUS_FETCH_BUF_EN
    push_done(1, 32'hAAAA_0001, 1, 0);
    req_fetch(32'h0000_0400); finish_txn("buf_hit", 1, 0);
`else
    push_bus(1, 0, 32'h0000_0400, '0, 4'hF, 1); push_done(1, 32'hFFFF_0000, 1, 0);
    req_fetch(32'h0000_0400); finish_txn("refetch", 1, 1);
`endif
    push_bus(0, 1, 32'h0000_0400, 32'h0000_0012, 4'hF, 1); push_done(0, '0, 0, 0);
    req_ls(0, 1, 32'h0000_0400, 32'h0000_0012, 4'hF); finish_txn("buf_store", 1, 1);
    cfg_rdata = 32'hBBBB_0002;
    push_bus(1, 0, 32'h0000_0400, '0, 4'hF, 1); push_done(1, 32'hBBBB_0002, 1, 0);
    req_fetch(32'h0000_0400); finish_txn("buf_refill", 1, 1);
    push_bus(0, 1, 32'h0000_0404, 32'h0000_0034, 4'hF, 1); push_done(0, '0, 0, 0);
    req_ls(0, 1, 32'h0000_0404, 32'h0000_0034, 4'hF); finish_txn("store_other", 1, 1);
    cfg_rdata = 32'hFFFF_1111;
`ifdef PIPE_MEMBUS_FETCH_BUF_EN
    push_done(1, 32'hBBBB_0002, 1, 0);
    req_fetch(32'h0000_0400); finish_txn("buf_hit2", 1, 0);
`else
    push_bus(1, 0, 32'h0000_0400, '0, 4'hF, 1); push_done(1, 32'hFFFF_1111, 1, 0);
    req_fetch(32'h0000_0400); finish_txn("refetch2", 1, 1);
`endif

    // Timeout on a fetch and on a store: strobe for 8 cycles, data 0, bus_error
    cfg_wait = 1000; cfg_rdata = 32'h7777_7777;
    push_bus(1, 0, 32'h0000_0500, '0, 4'hF, 8); push_done(1, 32'h0, 1, 1);
    req_fetch(32'h0000_0500); finish_txn("fetch_timeout", 1, 1);
    push_bus(0, 1, 32'h0000_0700, 32'h0102_0304, 4'b1100, 8); push_done(0, 32'h0, 1, 1);
    req_ls(0, 1, 32'h0000_0700, 32'h0102_0304, 4'b1100); finish_txn("store_timeout", 1, 1);
    do_reset();
    check("rst_clears_err1", 32'(bus_error), 32'd0);
    reset_n = 1'b1;

    // Misaligned fetch: no bus read, error and zero data
    cfg_wait = 0;
    push_done(1, 32'h0, 1, 1);
    req_fetch(32'h0000_1002); finish_txn("fetch_misaligned", 0, 0);
    check("misaligned_err_sticky", 32'(bus_error), 32'd1);
    do_reset();
    check("rst_clears_err2", 32'(bus_error), 32'd0);
    reset_n = 1'b1;

    // Reset mid-transfer: strobe drops, no done pulse
    cfg_wait = 1000;
    push_bus(1, 0, 32'h0000_0800, '0, 4'hF, 0);
    req_ls(1, 0, 32'h0000_0800, 32'h0, 4'hF);
    @(negedge clk); #1;
    release_req();
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_read", 32'(read), 32'd0);
    check("midrst_dones", 32'({if_done, ls_done}), 32'd0);
    check("midrst_busy", 32'(mem_busy), 32'd0);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("midrst_no_strobe", 32'(in_bus), 32'd0);

    check("final_bus_q", 32'(bus_q.size()), 32'd0);
    check("final_done_q", 32'(done_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
